fifo_wr_arb: RTL

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port among `NREQ` requesters in the `wclk` domain using round-robin burst arbitration. A grant is held for a whole burst, ending on `req_last` or after `MAXBURST` words, and the block stalls cleanly on `wfull`. It connects directly to the FIFO's `winc`, `wdata` and `wfull`.

---
 rtl/fifo_wr_arb.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter for the async FIFO write port.
// Grants one requester per burst and stalls on wfull.
module fifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 16,
  localparam int IW      = $clog2(NREQ),
  localparam int CW      = (MAXBURST > 1) ? $clog2(MAXBURST) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [IW:0]   NR   = (IW+1)'(NREQ);
  localparam logic [CW-1:0] CMAX = CW'(MAXBURST - 1);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic [IW-1:0]     nxt_owner;

  // rotate valids so bit 0 is rr_q, take the lowest set bit
  always_comb begin
    dbl      = {req_valid, req_valid};
    rot      = NREQ'(dbl >> rr_q);
    pick_vld = |req_valid;
    off      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum      = {1'b0, rr_q} + {1'b0, off};
    pick_idx = (sum >= NR) ? IW'(sum - NR) : IW'(sum);
  end

  assign nxt_owner = (owner_q == LAST) ? '0 : owner_q + 1'b1;

  // next state and write-port outputs
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        req_ready[owner_q] = ~wfull;
        winc = req_valid[owner_q] & ~wfull;
        if (winc) begin
          wdata = req_data[int'(owner_q)*DSIZE +: DSIZE];
          cnt_d = cnt_q + 1'b1;
          if (req_last[owner_q] || cnt_q == CMAX) begin
            state_d = IDLE;
            rr_d    = nxt_owner;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == XFER);

endmodule
